// File: rtl/uart_tx_hs.sv
// uart_tx_hs -- UART transmitter with a 1-entry holding register.
//
// Serialises bytes LSB-first: start bit (0), 8 data bits, optional parity
// bit, then one or two stop bits (1). Every bit lasts max(clks_per_bit_i,1)
// clock cycles. A byte queued in the holding register while a frame is in
// flight starts on the cycle right after the last stop bit, with no gap.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   clks_per_bit_i clock cycles per bit (0 is treated as 1)
//   parity_en_i    1 = append a parity bit
//   parity_odd_i   1 = odd parity, 0 = even parity
//   two_stop_i     1 = two stop bits
//   tx_valid_i     tx_byte_i is valid
//   tx_byte_i      byte to send
//   tx_ready_o     holding register empty, a byte can be accepted
//   tx_o           serial line (registered)
//   tx_active_o    a frame is in progress
//   tx_done_o      high during the final cycle of the last stop bit
module uart_tx_hs #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] clks_per_bit_i,
  input  logic        parity_en_i,
  input  logic        parity_odd_i,
  input  logic        two_stop_i,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_byte_i,
  output logic        tx_ready_o,
  output logic        tx_o,
  output logic        tx_active_o,
  output logic        tx_done_o
);

  // Three bits leave three illegal encodings, which recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_bit_q, par_bit_d;
  logic        par_en_q, par_en_d;
  logic        two_stop_q, two_stop_d;
  logic        second_stop_q, second_stop_d;
  logic [15:0] n_m1_q, n_m1_d;        // bit length minus one, latched per frame
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;

  logic accept;
  logic bit_end;
  logic load;
  logic done;

  assign accept  = tx_valid_i && !hold_valid_q;
  assign bit_end = (clk_cnt_q == n_m1_q);

  // NOTE: every signal written here gets its default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    shift_d       = shift_q;
    par_bit_d     = par_bit_q;
    par_en_d      = par_en_q;
    two_stop_d    = two_stop_q;
    second_stop_d = second_stop_q;
    n_m1_d        = n_m1_q;
    clk_cnt_d     = bit_end ? 16'd0 : clk_cnt_q + 16'd1;
    bit_idx_d     = bit_idx_q;
    tx_d          = tx_q;
    load          = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d      = IDLE_LEVEL;
        clk_cnt_d = 16'd0;
        load      = hold_valid_q;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            second_stop_d = 1'b0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d       = ST_STOP;
          second_stop_d = 1'b0;
          tx_d          = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (two_stop_q && !second_stop_q) begin
            second_stop_d = 1'b1;
          end else begin
            done    = 1'b1;
            state_d = ST_IDLE;
            tx_d    = IDLE_LEVEL;
            load    = hold_valid_q;   // chain straight into the next START
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = 16'd0;
        tx_d      = IDLE_LEVEL;
      end
    endcase

    // Moving a byte into the shifter also freezes the frame configuration.
    if (load) begin
      state_d       = ST_START;
      tx_d          = 1'b0;
      clk_cnt_d     = 16'd0;
      shift_d       = hold_q;
      par_bit_d     = (^hold_q) ^ parity_odd_i;
      par_en_d      = parity_en_i;
      two_stop_d    = two_stop_i;
      second_stop_d = 1'b0;
      n_m1_d        = (clks_per_bit_i == 16'd0) ? 16'd0 : clks_per_bit_i - 16'd1;
      hold_valid_d  = 1'b0;
    end

    if (accept) begin
      hold_valid_d = 1'b1;
      hold_d       = tx_byte_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      hold_valid_q  <= 1'b0;
      par_bit_q     <= 1'b0;
      par_en_q      <= 1'b0;
      two_stop_q    <= 1'b0;
      second_stop_q <= 1'b0;
      n_m1_q        <= 16'd0;
      clk_cnt_q     <= 16'd0;
      bit_idx_q     <= 3'd0;
      tx_q          <= IDLE_LEVEL;
    end else begin
      state_q       <= state_d;
      hold_valid_q  <= hold_valid_d;
      par_bit_q     <= par_bit_d;
      par_en_q      <= par_en_d;
      two_stop_q    <= two_stop_d;
      second_stop_q <= second_stop_d;
      n_m1_q        <= n_m1_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_idx_q     <= bit_idx_d;
      tx_q          <= tx_d;
    end
  end

  // NOTE: data-only registers are left out of reset; they are always
  // written before use, guarded by hold_valid_q or the state machine.
  always_ff @(posedge clk_i) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
  end

  assign tx_ready_o  = !hold_valid_q;
  assign tx_o        = tx_q;
  assign tx_active_o = (state_q != ST_IDLE);
  assign tx_done_o   = done;

endmodule

// File: tb/tb_uart_tx_hs.sv
// Self-checking bench for uart_tx_hs. A behavioural model predicts the line
// as a queue of per-cycle levels built from whole frames, plus a one-entry
// holding slot; DUT outputs are compared 1 time unit after every rising edge.
module tb_uart_tx_hs;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] clks_per_bit_i = 16'd4;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        two_stop_i = 1'b0;
  logic        tx_valid_i = 1'b0;
  logic [7:0]  tx_byte_i = 8'h00;
  logic        tx_ready_o;
  logic        tx_o;
  logic        tx_active_o;
  logic        tx_done_o;

  uart_tx_hs #(.IDLE_LEVEL(1'b1)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clks_per_bit_i (clks_per_bit_i),
    .parity_en_i    (parity_en_i),
    .parity_odd_i   (parity_odd_i),
    .two_stop_i     (two_stop_i),
    .tx_valid_i     (tx_valid_i),
    .tx_byte_i      (tx_byte_i),
    .tx_ready_o     (tx_ready_o),
    .tx_o           (tx_o),
    .tx_active_o    (tx_active_o),
    .tx_done_o      (tx_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: remaining line levels of the current frame, and the slot.
  bit         line_q[$];
  bit         m_hold_v = 1'b0;
  logic [7:0] m_hold_b = 8'h00;

  // Per-test observations.
  int active_cycles = 0;
  int done_pulses   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Append one whole frame, each bit repeated N cycles.
  task automatic push_frame(input logic [7:0] b, input logic [15:0] cpb,
                            input bit pen, input bit podd, input bit two);
    bit bits[$];
    int n;
    n = (cpb == 0) ? 1 : int'(cpb);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (pen) begin
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += b[i];
      bits.push_back(podd ? (ones % 2 == 0) : (ones % 2 == 1));
    end
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    foreach (bits[k]) for (int r = 0; r < n; r++) line_q.push_back(bits[k]);
  endtask

  // One clock edge: the model consumes the inputs that were present at the
  // edge, then every output is compared against the model.
  task automatic tick();
    bit         v_rst, v_valid, v_pen, v_podd, v_two, pre_ready;
    logic [7:0]  v_byte;
    logic [15:0] v_cpb;
    v_rst = rst_i; v_valid = tx_valid_i; v_byte = tx_byte_i;
    v_cpb = clks_per_bit_i; v_pen = parity_en_i; v_podd = parity_odd_i; v_two = two_stop_i;
    pre_ready = !m_hold_v;
    @(posedge clk_i);
    #1;
    if (v_rst) begin
      line_q.delete();
      m_hold_v = 1'b0;
    end else begin
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && m_hold_v) begin
        push_frame(m_hold_b, v_cpb, v_pen, v_podd, v_two);
        m_hold_v = 1'b0;
      end
      if (v_valid && pre_ready) begin
        m_hold_v = 1'b1;
        m_hold_b = v_byte;
      end
    end
    check("tx_o",        tx_o,        (line_q.size() > 0) ? line_q[0] : 1'b1);
    check("tx_active_o", tx_active_o, line_q.size() > 0);
    check("tx_ready_o",  tx_ready_o,  !m_hold_v);
    check("tx_done_o",   tx_done_o,   line_q.size() == 1);
    if (tx_active_o === 1'b1) active_cycles++;
    if (tx_done_o === 1'b1) done_pulses++;
  endtask

  // Hold tx_valid_i until the byte is taken; returns after the accept edge.
  task automatic send(input logic [7:0] b);
    bit acc;
    tx_valid_i = 1'b1;
    tx_byte_i  = b;
    acc = 1'b0;
    for (int i = 0; i < 2000 && !acc; i++) begin
      acc = !m_hold_v;
      tick();
    end
    tx_valid_i = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 4000 && (line_q.size() > 0 || m_hold_v); i++) tick();
    if (i == 4000) check("idle_timeout", 0, 1);
    tick();
  endtask

  task automatic set_cfg(input logic [15:0] cpb, input bit pen, input bit podd, input bit two);
    clks_per_bit_i = cpb; parity_en_i = pen; parity_odd_i = podd; two_stop_i = two;
  endtask

  task automatic clear_counts();
    active_cycles = 0;
    done_pulses   = 0;
  endtask

  initial begin
    // Reset state.
    rst_i = 1'b1;
    tx_valid_i = 1'b1;            // must be ignored during reset
    tick(); tick();
    tx_valid_i = 1'b0;
    rst_i = 1'b0;
    check("rst_tx",     tx_o,        1'b1);
    check("rst_active", tx_active_o, 1'b0);
    check("rst_ready",  tx_ready_o,  1'b1);
    check("rst_done",   tx_done_o,   1'b0);
    tick(); tick();

    // 1: N=4, 8N1, 0x55; line falls one edge after the accept edge.
    set_cfg(16'd4, 0, 0, 0);
    clear_counts();
    send(8'h55);
    check("t1_pre_fall", tx_o, 1'b1);
    tick();
    check("t1_fall", tx_o, 1'b0);
    wait_idle();
    check("t1_len",  active_cycles, 40);
    check("t1_done", done_pulses, 1);

    // 2: N=3 with parity on 0xA5, even then odd.
    set_cfg(16'd3, 1, 0, 0);
    clear_counts();
    send(8'hA5);
    wait_idle();
    check("t2_even_len", active_cycles, 33);
    set_cfg(16'd3, 1, 1, 0);
    clear_counts();
    send(8'hA5);
    wait_idle();
    check("t2_odd_len", active_cycles, 33);

    // 3: back-to-back 0x00 then 0xFF, no idle gap between frames.
    set_cfg(16'd4, 0, 0, 0);
    clear_counts();
    send(8'h00);
    send(8'hFF);
    check("t3_held_ready", tx_ready_o, 1'b0);
    wait_idle();
    check("t3_len",  active_cycles, 80);
    check("t3_done", done_pulses, 2);

    // 4: two stop bits, N=5; divisor changed mid-frame applies to next frame.
    set_cfg(16'd5, 0, 0, 1);
    clear_counts();
    send(8'h81);
    send(8'h42);
    repeat (7) tick();
    clks_per_bit_i = 16'd8;
    wait_idle();
    check("t4_len", active_cycles, 11 * 5 + 11 * 8);

    // 5: reset during data bit 3 with a byte held.
    set_cfg(16'd4, 0, 0, 0);
    clear_counts();
    send(8'h12);
    send(8'h99);
    repeat (15) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t5_tx",     tx_o,        1'b1);
    check("t5_active", tx_active_o, 1'b0);
    check("t5_ready",  tx_ready_o,  1'b1);
    clear_counts();
    repeat (60) tick();
    check("t5_nothing_sent", active_cycles, 0);
    check("t5_no_done",      done_pulses, 0);

    // 6: divisor 0 behaves as 1.
    set_cfg(16'd0, 0, 0, 0);
    clear_counts();
    send(8'h3C);
    wait_idle();
    check("t6_len", active_cycles, 10);

    // Randomised frames, bursts and mid-frame configuration changes.
    for (int it = 0; it < 40; it++) begin
      set_cfg(16'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 1'($urandom));
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) send(8'($urandom));
      repeat ($urandom_range(0, 6)) tick();
      if ($urandom_range(0, 2) == 0)
        set_cfg(16'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
